// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-cache read
// in flight, and feeds {pc, instruction} into the IF/ID register through its load/flush controls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_load,
  output logic        if_id_flush,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pendingPc;
  logic [31:0] r_bufPc;
  logic [31:0] r_bufInstr;
  logic        r_active;

  logic [31:0] w_nextPc;
  logic [31:0] w_targetPc;

  assign w_nextPc   = r_pc + PC_STEP;
  assign w_targetPc = redirect_pc & 32'hFFFF_FFFC;

  // r_active keeps the stage quiet until the first edge after reset release,
  // so a cache response still arriving from before the reset is never accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_pendingPc <= RESET_PC;
      r_bufPc     <= 32'd0;
      r_bufInstr  <= 32'd0;
      r_active    <= 1'b0;
    end else if (!r_active) begin
      r_active <= 1'b1;
    end else begin
      case (r_state)
        FETCH: begin
          if (redirect) begin
            if (imem_resp) begin
              r_pc <= w_targetPc;
            end else begin
              r_pendingPc <= w_targetPc;
              r_state     <= DISCARD;
            end
          end else if (imem_resp) begin
            if (stall) begin
              r_bufPc    <= r_pc;
              r_bufInstr <= imem_rdata;
              r_state    <= HOLD;
            end else begin
              r_pc <= w_nextPc;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            r_bufPc    <= 32'd0;
            r_bufInstr <= 32'd0;
            r_pc       <= w_targetPc;
            r_state    <= FETCH;
          end else if (!stall) begin
            r_pc    <= w_nextPc;
            r_state <= FETCH;
          end
        end
        DISCARD: begin
          // The stale request keeps r_pc on the bus; only the newest target survives.
          if (imem_resp) begin
            r_pc    <= redirect ? w_targetPc : r_pendingPc;
            r_state <= FETCH;
          end else if (redirect) begin
            r_pendingPc <= w_targetPc;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    imem_read    = 1'b0;
    imem_address = r_pc;
    if_id_load   = 1'b0;
    if_id_flush  = 1'b0;
    if_id_pc     = 32'd0;
    if_id_instr  = 32'd0;
    if (r_active) begin
      case (r_state)
        FETCH: begin
          imem_read = 1'b1;
          if (redirect) begin
            if_id_load  = 1'b1;
            if_id_flush = 1'b1;
          end else if (imem_resp && !stall) begin
            if_id_load  = 1'b1;
            if_id_pc    = r_pc;
            if_id_instr = imem_rdata;
          end
        end
        HOLD: begin
          if (redirect) begin
            if_id_load  = 1'b1;
            if_id_flush = 1'b1;
          end else if (!stall) begin
            if_id_load  = 1'b1;
            if_id_pc    = r_bufPc;
            if_id_instr = r_bufInstr;
          end
        end
        DISCARD: begin
          imem_read = 1'b1;
          if (redirect) begin
            if_id_load  = 1'b1;
            if_id_flush = 1'b1;
          end
        end
        default: imem_read = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a variable-latency cache model answers requests,
// and a scoreboard queue holds the PCs expected to reach IF/ID in order.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_load;
  logic        if_id_flush;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int          checks = 0;
  int          errors = 0;
  int          flushCount = 0;
  int          latency = 1;
  int          waitCnt = 0;
  logic        rstDrive = 1'b0;
  logic        injectResp = 1'b0;
  logic [31:0] sbQ[$];

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .if_id_load   (if_id_load),
    .if_id_flush  (if_id_flush),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #90000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] instrOf(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle at the falling edge: cache model, reset and EX/decode inputs,
  // then samples just before the rising edge and retires any delivered instruction.
  task automatic applyStimulus(input logic st, input logic rd, input logic [31:0] rpc);
    logic [31:0] expPc;
    @(negedge clk);
    if (injectResp) begin
      imem_resp  = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      injectResp = 1'b0;
      waitCnt    = 0;
    end else if (imem_read === 1'b1) begin
      if (waitCnt + 1 >= latency) begin
        imem_resp  = 1'b1;
        imem_rdata = instrOf(imem_address);
        waitCnt    = 0;
      end else begin
        imem_resp  = 1'b0;
        imem_rdata = 32'h0;
        waitCnt++;
      end
    end else begin
      imem_resp  = 1'b0;
      imem_rdata = 32'h0;
      waitCnt    = 0;
    end
    rst         = rstDrive;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    #4;
    if (if_id_flush === 1'b1) flushCount++;
    if (rst === 1'b1 && if_id_load === 1'b1 && if_id_flush === 1'b0) begin
      checks++;
      assert (sbQ.size() > 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_load: observed pc %h, required no delivery", if_id_pc);
      end
      if (sbQ.size() > 0) begin
        expPc = sbQ.pop_front();
        checkOutput("sb_pc", if_id_pc, expPc);
        checkOutput("sb_instr", if_id_instr, instrOf(expPc));
      end
    end
  endtask

  task automatic checkStep(input string tag, input logic expRead, input logic [31:0] expAddr,
                           input logic expLoad, input logic expFlush);
    checkOutput({tag, "_read"}, {31'd0, imem_read}, {31'd0, expRead});
    checkOutput({tag, "_addr"}, imem_address, expAddr);
    checkOutput({tag, "_load"}, {31'd0, if_id_load}, {31'd0, expLoad});
    checkOutput({tag, "_flush"}, {31'd0, if_id_flush}, {31'd0, expFlush});
  endtask

  task automatic checkResetOutputs(input string tag);
    checkStep(tag, 1'b0, 32'h60, 1'b0, 1'b0);
    checkOutput({tag, "_pc"}, if_id_pc, 32'd0);
    checkOutput({tag, "_instr"}, if_id_instr, 32'd0);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_resp = 1'b0; imem_rdata = 32'd0;

    // Reset, then release: the request only starts after the first edge.
    applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkResetOutputs("reset");
    rstDrive = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkStep("release", 1'b0, 32'h60, 1'b0, 1'b0);

    // Zero-wait cache: one instruction per cycle.
    for (int i = 0; i < 4; i++) sbQ.push_back(32'h60 + 32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkStep("stream", 1'b1, 32'h60 + 32'(4 * i), 1'b1, 1'b0);
    end

    // Three-cycle latency: address held, one load on the response cycle.
    latency = 3;
    sbQ.push_back(32'h70);
    applyStimulus(1'b0, 1'b0, 32'd0); checkStep("lat_w1", 1'b1, 32'h70, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0); checkStep("lat_w2", 1'b1, 32'h70, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0); checkStep("lat_rsp", 1'b1, 32'h70, 1'b1, 1'b0);

    // Stall on the response cycle, hold for two cycles, then release.
    latency = 1;
    sbQ.push_back(32'h74);
    applyStimulus(1'b1, 1'b0, 32'd0); checkStep("stall_rsp", 1'b1, 32'h74, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0); checkStep("hold1", 1'b0, 32'h74, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0); checkStep("hold2", 1'b0, 32'h74, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0); checkStep("unstall", 1'b0, 32'h74, 1'b1, 1'b0);
    sbQ.push_back(32'h78);
    applyStimulus(1'b0, 1'b0, 32'd0); checkStep("after_hold", 1'b1, 32'h78, 1'b1, 1'b0);

    // Redirect while a request is outstanding: address stays until the stale response.
    latency = 3;
    applyStimulus(1'b0, 1'b0, 32'd0); checkStep("pend_w1", 1'b1, 32'h7C, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h200); checkStep("redir_pend", 1'b1, 32'h7C, 1'b1, 1'b1);
    checkOutput("flush_pc_zero", if_id_pc, 32'd0);
    checkOutput("flush_instr_zero", if_id_instr, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0); checkStep("discard_rsp", 1'b1, 32'h7C, 1'b0, 1'b0);
    latency = 1;
    sbQ.push_back(32'h200);
    applyStimulus(1'b0, 1'b0, 32'd0); checkStep("redir_first", 1'b1, 32'h200, 1'b1, 1'b0);

    // Repeated redirects inside DISCARD: the latest target wins.
    latency = 4;
    applyStimulus(1'b0, 1'b1, 32'h250); checkStep("disc_r1", 1'b1, 32'h204, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h300); checkStep("disc_r2", 1'b1, 32'h204, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h400); checkStep("disc_r3", 1'b1, 32'h204, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0);   checkStep("disc_rsp", 1'b1, 32'h204, 1'b0, 1'b0);
    latency = 1;
    sbQ.push_back(32'h400);
    applyStimulus(1'b0, 1'b0, 32'd0);   checkStep("disc_new", 1'b1, 32'h400, 1'b1, 1'b0);

    // Redirect coinciding with the response while in DISCARD.
    latency = 2;
    applyStimulus(1'b0, 1'b1, 32'h500); checkStep("dr_enter", 1'b1, 32'h404, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h600); checkStep("dr_both", 1'b1, 32'h404, 1'b1, 1'b1);
    latency = 1;
    sbQ.push_back(32'h600);
    applyStimulus(1'b0, 1'b0, 32'd0);   checkStep("dr_new", 1'b1, 32'h600, 1'b1, 1'b0);

    // Redirect together with a response in FETCH, then in HOLD under stall.
    applyStimulus(1'b0, 1'b1, 32'h700); checkStep("fr_both", 1'b1, 32'h604, 1'b1, 1'b1);
    sbQ.push_back(32'h700);
    applyStimulus(1'b0, 1'b0, 32'd0);   checkStep("fr_new", 1'b1, 32'h700, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0);   checkStep("hr_stall", 1'b1, 32'h704, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h800); checkStep("hr_redir", 1'b0, 32'h704, 1'b1, 1'b1);
    sbQ.push_back(32'h800);
    applyStimulus(1'b0, 1'b0, 32'd0);   checkStep("hr_new", 1'b1, 32'h800, 1'b1, 1'b0);

    // Reset in the middle of a request, with a late response after release.
    latency = 5;
    applyStimulus(1'b0, 1'b0, 32'd0);   checkStep("rst_pend", 1'b1, 32'h804, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rstDrive = 1'b0;
    rst = 1'b0;
    #1;
    checkResetOutputs("async_rst");
    applyStimulus(1'b0, 1'b0, 32'd0);
    rstDrive = 1'b1;
    injectResp = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0);   checkStep("late_resp", 1'b0, 32'h60, 1'b0, 1'b0);
    latency = 1;
    sbQ.push_back(32'h60);
    applyStimulus(1'b0, 1'b0, 32'd0);   checkStep("restart", 1'b1, 32'h60, 1'b1, 1'b0);

    // Target alignment and PC wrap-around.
    applyStimulus(1'b0, 1'b1, 32'h1FF); checkStep("align_redir", 1'b1, 32'h64, 1'b1, 1'b1);
    sbQ.push_back(32'h1FC);
    applyStimulus(1'b0, 1'b0, 32'd0);   checkStep("align_fetch", 1'b1, 32'h1FC, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFE); checkStep("wrap_redir", 1'b1, 32'h200, 1'b1, 1'b1);
    sbQ.push_back(32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'd0);   checkStep("wrap_top", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    sbQ.push_back(32'h0);
    applyStimulus(1'b0, 1'b0, 32'd0);   checkStep("wrap_zero", 1'b1, 32'h0, 1'b1, 1'b0);

    checkOutput("flush_count", 32'(flushCount), 32'd10);
    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
